issue_ctrl: RTL and testbench

Issue controller between the instruction decoder and the back-end resources (ROB, reservation station, load/store buffer, register-file rename port). It holds one decoded instruction in a skid slot and fires it once the ROB and the target station both have room. Firing writes all affected resources in the same cycle. It serializes JALR by blocking issue until the target is resolved, and it drops everything on rollback.

---
 rtl/issue_ctrl.sv | 173 +++++++++++++++++
 tb/tb_issue_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// issue_ctrl: single-slot issue controller between decoder and back end.
// Holds one decoded instruction and fires it into the ROB plus either the
// RS or the LSB once both have room. JALR blocks further issue until its
// target resolves. Rollback empties the slot.
//
// Optional feature macro: ISSUE_STAT_EN (fire / stall statistics counters).
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   rdy_in                  global ready (low freezes everything)
//   rollback_in             flush
//   id_*                    decoder handshake and instruction fields
//   rob/rs/lsb_full_in      back-end full flags
//   rob_ava_id_in           next free ROB tag
//   jalr_done_in            JALR target resolved
//   rob/rs/lsb_we_out       write strobes
//   issue_*_out             slot contents plus ROB tag
//   rf_rename_*_out         rename-table write
//   issue_cnt_out, stall_cnt_out  statistics

`ifndef REGBW
`define REGBW 5
`endif
`ifndef ROBBW
`define ROBBW 4
`endif
`ifndef ALU
`define ALU 3'd0
`endif
`ifndef BRC
`define BRC 3'd1
`endif
`ifndef JMP
`define JMP 3'd2
`endif
`ifndef LD
`define LD 3'd3
`endif
`ifndef ST
`define ST 3'd4
`endif
`ifndef JALR
`define JALR 6'd25
`endif

module issue_ctrl #(
  parameter int PAYLOAD_W = 120
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy_in,
  input  logic                 rollback_in,
  input  logic                 id_flag_in,
  input  logic [2:0]           id_type_in,
  input  logic [5:0]           id_code_in,
  input  logic [`REGBW-1:0]    id_rd_in,
  input  logic [PAYLOAD_W-1:0] id_payload_in,
  output logic                 id_ready_out,
  input  logic                 rob_full_in,
  input  logic                 rs_full_in,
  input  logic                 lsb_full_in,
  input  logic [`ROBBW-1:0]    rob_ava_id_in,
  input  logic                 jalr_done_in,
  output logic                 rob_we_out,
  output logic                 rs_we_out,
  output logic                 lsb_we_out,
  output logic [2:0]           issue_type_out,
  output logic [5:0]           issue_code_out,
  output logic [`REGBW-1:0]    issue_rd_out,
  output logic [PAYLOAD_W-1:0] issue_payload_out,
  output logic [`ROBBW-1:0]    issue_rob_id_out,
  output logic                 rf_rename_we_out,
  output logic [`REGBW-1:0]    rf_rename_rd_out,
  output logic [`ROBBW-1:0]    rf_rename_rob_out,
  output logic [31:0]          issue_cnt_out,
  output logic [31:0]          stall_cnt_out
);

  typedef enum logic [1:0] {EMPTY, FULL, JWAIT} state_t;

  state_t               state;
  logic [2:0]           s_type;
  logic [5:0]           s_code;
  logic [`REGBW-1:0]    s_rd;
  logic [PAYLOAD_W-1:0] s_payload;

  logic is_mem, tgt_full, fire, accept, show, is_jalr, live;

  assign live     = rdy_in && !rollback_in;
  assign is_mem   = (s_type == `LD) || (s_type == `ST);
  assign tgt_full = is_mem ? lsb_full_in : rs_full_in;
  assign is_jalr  = (s_code == `JALR);
  assign fire     = (state == FULL) && live && !rob_full_in && !tgt_full;
  // rst_n term keeps the handshake low while reset is asserted.
  assign id_ready_out = rst_n && live &&
                        ((state == EMPTY) || (fire && !is_jalr));
  assign accept   = id_flag_in && id_ready_out;
  assign show     = (state != EMPTY);

  assign rob_we_out = fire;
  assign rs_we_out  = fire && !is_mem;
  assign lsb_we_out = fire && is_mem;

  // Slot contents are only presented while occupied; stale data after a
  // plain fire stays hidden.
  assign issue_type_out    = show ? s_type    : '0;
  assign issue_code_out    = show ? s_code    : '0;
  assign issue_rd_out      = show ? s_rd      : '0;
  assign issue_payload_out = show ? s_payload : '0;
  assign issue_rob_id_out  = show ? rob_ava_id_in : '0;

  assign rf_rename_we_out  = fire && (s_rd != '0);
  assign rf_rename_rd_out  = issue_rd_out;
  assign rf_rename_rob_out = issue_rob_id_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      s_type    <= '0;
      s_code    <= '0;
      s_rd      <= '0;
      s_payload <= '0;
    end else if (rdy_in) begin
      if (rollback_in) begin
        state     <= EMPTY;
        s_type    <= '0;
        s_code    <= '0;
        s_rd      <= '0;
        s_payload <= '0;
      end else begin
        if (accept) begin
          s_type    <= id_type_in;
          s_code    <= id_code_in;
          s_rd      <= id_rd_in;
          s_payload <= id_payload_in;
        end
        unique case (state)
          EMPTY: if (accept) state <= FULL;
          FULL: begin
            if (fire) begin
              if (is_jalr)     state <= JWAIT;
              else if (accept) state <= FULL;
              else             state <= EMPTY;
            end
          end
          JWAIT: if (jalr_done_in) state <= EMPTY;
          default: state <= EMPTY;
        endcase
      end
    end
  end

`ifdef ISSUE_STAT_EN
  logic [31:0] issue_cnt, stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fire) issue_cnt <= issue_cnt + 32'd1;
      if ((state == FULL) && live && !fire) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign issue_cnt_out = issue_cnt;
  assign stall_cnt_out = stall_cnt;
`else
  assign issue_cnt_out = '0;
  assign stall_cnt_out = '0;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Testbench for issue_ctrl: directed scenarios followed by randomized
// traffic, checked each cycle against a slot-occupancy reference model.

`ifndef REGBW
`define REGBW 5
`endif
`ifndef ROBBW
`define ROBBW 4
`endif
`ifndef ALU
`define ALU 3'd0
`endif
`ifndef JMP
`define JMP 3'd2
`endif
`ifndef LD
`define LD 3'd3
`endif
`ifndef ST
`define ST 3'd4
`endif
`ifndef JALR
`define JALR 6'd25
`endif

module tb_issue_ctrl;
  localparam int PW = 120;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy_in, rollback_in, id_flag_in;
  logic [2:0] id_type_in;
  logic [5:0] id_code_in;
  logic [`REGBW-1:0] id_rd_in;
  logic [PW-1:0] id_payload_in;
  logic id_ready_out;
  logic rob_full_in, rs_full_in, lsb_full_in;
  logic [`ROBBW-1:0] rob_ava_id_in;
  logic jalr_done_in;
  logic rob_we_out, rs_we_out, lsb_we_out;
  logic [2:0] issue_type_out;
  logic [5:0] issue_code_out;
  logic [`REGBW-1:0] issue_rd_out;
  logic [PW-1:0] issue_payload_out;
  logic [`ROBBW-1:0] issue_rob_id_out;
  logic rf_rename_we_out;
  logic [`REGBW-1:0] rf_rename_rd_out;
  logic [`ROBBW-1:0] rf_rename_rob_out;
  logic [31:0] issue_cnt_out, stall_cnt_out;

  issue_ctrl #(.PAYLOAD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .rdy_in(rdy_in), .rollback_in(rollback_in),
    .id_flag_in(id_flag_in), .id_type_in(id_type_in), .id_code_in(id_code_in),
    .id_rd_in(id_rd_in), .id_payload_in(id_payload_in), .id_ready_out(id_ready_out),
    .rob_full_in(rob_full_in), .rs_full_in(rs_full_in), .lsb_full_in(lsb_full_in),
    .rob_ava_id_in(rob_ava_id_in), .jalr_done_in(jalr_done_in),
    .rob_we_out(rob_we_out), .rs_we_out(rs_we_out), .lsb_we_out(lsb_we_out),
    .issue_type_out(issue_type_out), .issue_code_out(issue_code_out),
    .issue_rd_out(issue_rd_out), .issue_payload_out(issue_payload_out),
    .issue_rob_id_out(issue_rob_id_out), .rf_rename_we_out(rf_rename_we_out),
    .rf_rename_rd_out(rf_rename_rd_out), .rf_rename_rob_out(rf_rename_rob_out),
    .issue_cnt_out(issue_cnt_out), .stall_cnt_out(stall_cnt_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: an instruction is either absent, waiting to issue,
  // or already issued as a JALR that holds the front end.
  bit m_occ, m_jwait;
  logic [2:0] m_type;
  logic [5:0] m_code;
  logic [`REGBW-1:0] m_rd;
  logic [PW-1:0] m_pay;
  logic [31:0] m_issued, m_stalls;
  int fires_seen;

  function automatic bit pct(int p);
    return $urandom_range(99, 0) < p;
  endfunction

  task automatic set_idle();
    rdy_in = 1'b1; rollback_in = 1'b0; id_flag_in = 1'b0;
    id_type_in = `ALU; id_code_in = 6'd0; id_rd_in = '0; id_payload_in = '0;
    rob_full_in = 1'b0; rs_full_in = 1'b0; lsb_full_in = 1'b0;
    rob_ava_id_in = '0; jalr_done_in = 1'b0;
  endtask

  task automatic set_inst(input logic [2:0] t, input logic [5:0] c, input logic [`REGBW-1:0] rd);
    id_flag_in = 1'b1; id_type_in = t; id_code_in = c; id_rd_in = rd;
    id_payload_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One clock: inputs already applied after a negedge; check, then advance.
  task automatic cyc();
    bit mem, blocked, f, rdy_e, acc, stall;
    #2;
    mem     = (m_type == `LD) || (m_type == `ST);
    blocked = rob_full_in || (mem ? lsb_full_in : rs_full_in);
    f       = m_occ && !m_jwait && rdy_in && !rollback_in && !blocked;
    rdy_e   = rdy_in && !rollback_in &&
              (!m_occ || (f && m_code != `JALR));
    acc     = rdy_e && id_flag_in;
    stall   = m_occ && !m_jwait && rdy_in && !rollback_in && !f;

    chk("id_ready", id_ready_out, rdy_e);
    chk("rob_we", rob_we_out, f);
    chk("rs_we", rs_we_out, f && !mem);
    chk("lsb_we", lsb_we_out, f && mem);
    chk("rename_we", rf_rename_we_out, f && (m_rd != 0));
    if (m_occ) begin
      chk("issue_type", issue_type_out, m_type);
      chk("issue_code", issue_code_out, m_code);
      chk("issue_rd", issue_rd_out, m_rd);
      chk("issue_payload", issue_payload_out, m_pay);
      chk("issue_rob_id", issue_rob_id_out, rob_ava_id_in);
    end
    if (f) begin
      chk("rename_rd", rf_rename_rd_out, m_rd);
      chk("rename_rob", rf_rename_rob_out, rob_ava_id_in);
      fires_seen++;
    end
`ifdef ISSUE_STAT_EN
    chk("issue_cnt", issue_cnt_out, m_issued);
    chk("stall_cnt", stall_cnt_out, m_stalls);
`else
    chk("issue_cnt", issue_cnt_out, 32'd0);
    chk("stall_cnt", stall_cnt_out, 32'd0);
`endif

    if (rdy_in) begin
      if (f) m_issued = m_issued + 1;
      if (stall) m_stalls = m_stalls + 1;
      if (rollback_in) begin
        m_occ = 0; m_jwait = 0;
      end else if (m_jwait) begin
        if (jalr_done_in) begin m_occ = 0; m_jwait = 0; end
      end else if (f && m_code == `JALR) begin
        m_jwait = 1;
      end else if (f || !m_occ) begin
        m_occ = acc;
        if (acc) begin
          m_type = id_type_in; m_code = id_code_in;
          m_rd = id_rd_in; m_pay = id_payload_in;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int f0;
    int s0;
    m_occ = 0; m_jwait = 0; m_type = '0; m_code = '0; m_rd = '0; m_pay = '0;
    m_issued = '0; m_stalls = '0; fires_seen = 0;
    set_idle();
    id_flag_in = 1'b1;
    rob_ava_id_in = 4'd7;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_id_ready", id_ready_out, 1'b0);
    chk("rst_rob_we", rob_we_out, 1'b0);
    chk("rst_issue_type", issue_type_out, 3'd0);
    chk("rst_issue_rob_id", issue_rob_id_out, 4'd0);
    chk("rst_rename_rob", rf_rename_rob_out, 4'd0);
    chk("rst_issue_cnt", issue_cnt_out, 32'd0);
    rst_n = 1'b1;
    set_idle();
    @(negedge clk);

    // ALU rd=5 with ROB tag 3
    set_inst(`ALU, 6'd1, 5'd5); rob_ava_id_in = 4'd3; cyc();
    id_flag_in = 1'b0; f0 = fires_seen; cyc();
    chk("alu_fired", fires_seen - f0, 1);

    // Back-to-back stream of four ALU ops
    f0 = fires_seen;
    for (int i = 0; i < 4; i++) begin
      set_inst(`ALU, 6'd2, 5'(i + 1)); rob_ava_id_in = 4'(i); cyc();
    end
    id_flag_in = 1'b0; cyc();
    chk("stream_fires", fires_seen - f0, 4);

    // Store blocked by a full LSB for three cycles
    s0 = m_stalls;
    set_inst(`ST, 6'd3, 5'd0); cyc();
    id_flag_in = 1'b0; lsb_full_in = 1'b1;
    f0 = fires_seen;
    repeat (3) cyc();
    chk("st_blocked", fires_seen - f0, 0);
    lsb_full_in = 1'b0; cyc();
    chk("st_fired", fires_seen - f0, 1);
`ifdef ISSUE_STAT_EN
    chk("st_stalls", stall_cnt_out - s0, 32'd3);
`endif

    // JALR holds issue until resolved
    set_inst(`JMP, `JALR, 5'd1); cyc();
    set_inst(`ALU, 6'd4, 5'd9);
    repeat (6) cyc();
    chk("jalr_wait", m_jwait, 1'b1);
    jalr_done_in = 1'b1; id_flag_in = 1'b0; cyc();
    jalr_done_in = 1'b0; cyc();
    chk("jalr_released", id_ready_out, 1'b1);

    // Rollback while blocked by ROB full
    set_inst(`LD, 6'd5, 5'd7); cyc();
    id_flag_in = 1'b0; rob_full_in = 1'b1; f0 = fires_seen;
    cyc();
    rollback_in = 1'b1; cyc();
    rollback_in = 1'b0; rob_full_in = 1'b0; repeat (2) cyc();
    chk("rb_never_issued", fires_seen - f0, 0);

    // Global ready low for two cycles
    set_inst(`ALU, 6'd6, 5'd3); cyc();
    id_flag_in = 1'b0; rdy_in = 1'b0; f0 = fires_seen;
    repeat (2) cyc();
    chk("rdy_low_hold", fires_seen - f0, 0);
    rdy_in = 1'b1; cyc();
    chk("rdy_resume", fires_seen - f0, 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rdy_in = pct(90);
      rollback_in = rdy_in && pct(4);
      jalr_done_in = pct(25);
      rob_full_in = pct(20);
      rs_full_in = pct(20);
      lsb_full_in = pct(20);
      rob_ava_id_in = 4'($urandom);
      if (pct(70))
        set_inst(3'($urandom_range(4, 0)), pct(15) ? `JALR : 6'($urandom_range(24, 0)),
                 pct(20) ? 5'd0 : 5'($urandom));
      else
        id_flag_in = 1'b0;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
